// File: rtl/topk_stream_serializer_if.sv
// Bundle of all non-clock signals of topk_stream_serializer.
//   slave  modport : used by the serializer itself.
//   master modport : used by whoever drives frames in and consumes the stream.
// Signals:
//   in_valid / in_data          one-cycle frame strobe and K x 16-bit signed frame
//   out_valid/out_ready         element stream handshake
//   out_data/out_idx/out_last   element value, its position in the frame, last flag
//   level                       frames buffered (including a partially drained head)
//   overflow/drop_cnt/ovf_clr   sticky drop flag, saturating drop count, clear strobe
interface topk_stream_serializer_if #(
    parameter int M     = 3,
    parameter int DEPTH = 4
);
    localparam int K  = 1 << M;
    localparam int LW = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic [K*16-1:0]      in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [15:0]   out_data;
    logic [M-1:0]         out_idx;
    logic                 out_last;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic [7:0]           drop_cnt;
    logic                 ovf_clr;

    modport slave (
        input  in_valid, in_data, out_ready, ovf_clr,
        output out_valid, out_data, out_idx, out_last, level, overflow, drop_cnt
    );

    modport master (
        output in_valid, in_data, out_ready, ovf_clr,
        input  out_valid, out_data, out_idx, out_last, level, overflow, drop_cnt
    );
endinterface

// File: rtl/topk_stream_serializer.sv
// Frame-to-element serializer behind a partial sorter.
// Whole K-element frames arrive as single-cycle strobes with no backpressure;
// they are held in a DEPTH-entry circular frame FIFO and streamed out one
// 16-bit signed element per transfer, element 0 first. Frames arriving while
// the FIFO is full (and no head pop happens that cycle) are dropped and counted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    topk_stream_serializer_if.slave (frame input, element stream, status)
module topk_stream_serializer #(
    parameter int M     = 3,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    topk_stream_serializer_if.slave       bus
);
    localparam int K      = 1 << M;
    localparam int DATA_W = 16;
    localparam int PW     = $clog2(DEPTH);
    localparam int LW     = PW + 1;
    localparam logic [M-1:0]  LAST_IDX = M'(K - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Frame storage carries no reset; validity is tracked by level_q alone.
    logic [K*DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [M-1:0]  elem_q,   elem_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;
    logic [7:0]    drop_q,   drop_d;

    logic vld, xfer, pop, full, wr, drop;
    logic [K*DATA_W-1:0]      head_frame;
    logic signed [DATA_W-1:0] head_elem;

    assign vld  = (level_q != '0);
    assign xfer = vld & bus.out_ready;
    assign pop  = xfer & (elem_q == LAST_IDX);
    assign full = (level_q == FULL_LVL);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign wr   = bus.in_valid & (~full | pop);
    assign drop = bus.in_valid & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        elem_d   = elem_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (wr)   wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (xfer) elem_d   = pop ? '0 : elem_q + M'(1);

        case ({wr, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A drop wins over a clear: the counter restarts at 1, not 0.
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = bus.ovf_clr ? 8'd1 : sat_inc8(drop_q);
        end else if (bus.ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            elem_q   <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            elem_q   <= elem_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign head_frame = mem_q[rd_ptr_q];
    assign head_elem  = head_frame[{elem_q, 4'b0000} +: DATA_W];

    // Outputs are forced to zero whenever nothing is buffered, which also
    // zeroes them immediately when rst_n drops.
    assign bus.out_valid = vld;
    assign bus.out_data  = vld ? head_elem : '0;
    assign bus.out_idx   = vld ? elem_q : '0;
    assign bus.out_last  = vld & (elem_q == LAST_IDX);
    assign bus.level     = level_q;
    assign bus.overflow  = ovf_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_topk_stream_serializer.sv
// Directed bench for topk_stream_serializer with M=3 (K=8), DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_topk_stream_serializer;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    topk_stream_serializer_if #(.M(3), .DEPTH(4)) bus ();

    topk_stream_serializer #(.M(3), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [127:0] mkframe(input int base, input int step);
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(base + step * i);
        return v;
    endfunction

    function automatic logic signed [15:0] elem(input int base, input int step, input int i);
        return 16'(base + step * i);
    endfunction

    // Checks the streamed elements of one frame with out_ready already at 1.
    task automatic drain_frame(input string name, input int base, input int step);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== elem(base, step, i) ||
                bus.out_idx !== 3'(i) || bus.out_last !== (i == 7)) begin
                bad++;
                $display("FAIL %s elem %0d: got v=%0b d=%0d idx=%0d last=%0b want v=1 d=%0d idx=%0d last=%0b",
                         name, i, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last,
                         elem(base, step, i), i, (i == 7));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.out_idx !== 3'd0 ||
            bus.out_last !== 1'b0 || bus.level !== 3'd0 || bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_hold: got v=%0b d=%0d idx=%0d last=%0b lvl=%0d ovf=%0b drop=%0d want all 0",
                     bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.level, bus.overflow, bus.drop_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
            bad++;
            $display("FAIL reset_release: got v=%0b lvl=%0d want v=0 lvl=0", bus.out_valid, bus.level);
        end
    endtask

    task automatic test_single_frame();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = mkframe(70, -10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain_frame("single", 70, -10);
        total++;
        if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 ||
            bus.out_idx !== 3'd0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL single_empty: got lvl=%0d v=%0b d=%0d idx=%0d last=%0b want all 0",
                     bus.level, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last);
        end
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            bus.in_valid = 1'b1; bus.in_data = mkframe(-1000 * f, 7);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
            bad++;
            $display("FAIL ovf_state: got lvl=%0d ovf=%0b drop=%0d want lvl=4 ovf=1 drop=1",
                     bus.level, bus.overflow, bus.drop_cnt);
        end
        bus.out_ready = 1'b1;
        for (int f = 1; f <= 4; f++) drain_frame("ovf_drain", -1000 * f, 7);
        bus.out_ready = 1'b0;
        total++;
        if (bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_empty: got lvl=%0d v=%0b want lvl=0 v=0", bus.level, bus.out_valid);
        end
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        total++;
        if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL ovf_clear: got ovf=%0b drop=%0d want 0 0", bus.overflow, bus.drop_cnt);
        end
    endtask

    task automatic test_pop_write();
        bus.out_ready = 1'b0;
        for (int f = 1; f <= 4; f++) begin
            bus.in_valid = 1'b1; bus.in_data = mkframe(100 * f, 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (7) @(negedge clk);
        total++;
        if (bus.out_idx !== 3'd7 || bus.out_last !== 1'b1 || bus.level !== 3'd4) begin
            bad++;
            $display("FAIL popwr_pre: got idx=%0d last=%0b lvl=%0d want idx=7 last=1 lvl=4",
                     bus.out_idx, bus.out_last, bus.level);
        end
        bus.in_valid = 1'b1; bus.in_data = mkframe(500, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0 ||
            bus.out_idx !== 3'd0 || bus.out_data !== 16'sd200) begin
            bad++;
            $display("FAIL popwr_post: got lvl=%0d ovf=%0b drop=%0d idx=%0d d=%0d want lvl=4 ovf=0 drop=0 idx=0 d=200",
                     bus.level, bus.overflow, bus.drop_cnt, bus.out_idx, bus.out_data);
        end
        for (int f = 2; f <= 5; f++) drain_frame("popwr_drain", 100 * f, 1);
        total++;
        if (bus.level !== 3'd0) begin
            bad++;
            $display("FAIL popwr_empty: got lvl=%0d want 0", bus.level);
        end
    endtask

    task automatic test_random_stall();
        logic [31:0]        pat = 32'b1011_0010_1110_0101_1001_1100_0110_1011;
        int                 q[$];
        int                 eidx = 0;
        int                 sent = 0;
        bit                 stalled = 0;
        bit                 rdy, wr;
        logic signed [15:0] pdata;
        logic [2:0]         pidx;
        logic               plast;
        for (int c = 0; c < 400 && !(sent == 6 && q.size() == 0); c++) begin
            total++;
            if (q.size() > 0) begin
                if (bus.out_valid !== 1'b1 || bus.out_data !== elem(q[0], 3, eidx) ||
                    bus.out_idx !== 3'(eidx) || bus.out_last !== (eidx == 7)) begin
                    bad++;
                    $display("FAIL stall_order c=%0d: got v=%0b d=%0d idx=%0d last=%0b want v=1 d=%0d idx=%0d last=%0b",
                             c, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last,
                             elem(q[0], 3, eidx), eidx, (eidx == 7));
                end
            end else if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_idle c=%0d: got v=%0b want 0", c, bus.out_valid);
            end
            if (stalled) begin
                total++;
                if (bus.out_data !== pdata || bus.out_idx !== pidx || bus.out_last !== plast) begin
                    bad++;
                    $display("FAIL stall_hold c=%0d: got d=%0d idx=%0d last=%0b want d=%0d idx=%0d last=%0b",
                             c, bus.out_data, bus.out_idx, bus.out_last, pdata, pidx, plast);
                end
            end
            pdata = bus.out_data; pidx = bus.out_idx; plast = bus.out_last;
            rdy = pat[c % 32];
            wr  = (sent < 6) && (q.size() < 4) && (c % 3 == 0);
            bus.out_ready = rdy;
            bus.in_valid  = wr;
            bus.in_data   = mkframe(sent * 1111 - 3000, 3);
            stalled = (q.size() > 0) && !rdy;
            if (q.size() > 0 && rdy) begin
                if (eidx == 7) begin
                    void'(q.pop_front());
                    eidx = 0;
                end else begin
                    eidx++;
                end
            end
            if (wr) begin
                q.push_back(sent * 1111 - 3000);
                sent++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++;
        if (!(sent == 6 && q.size() == 0)) begin
            bad++;
            $display("FAIL stall_timeout: got sent=%0d pending=%0d want 6 0", sent, q.size());
        end
        total++;
        if (bus.level !== 3'd0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL stall_end: got lvl=%0d ovf=%0b want 0 0", bus.level, bus.overflow);
        end
    endtask

    task automatic test_midframe_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = mkframe(40, 1);
        @(negedge clk);
        bus.in_data = mkframe(60, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.out_idx !== 3'd3 || bus.out_data !== 16'sd43 || bus.level !== 3'd2) begin
            bad++;
            $display("FAIL rst_pre: got idx=%0d d=%0d lvl=%0d want idx=3 d=43 lvl=2",
                     bus.out_idx, bus.out_data, bus.level);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.out_idx !== 3'd0 ||
            bus.out_last !== 1'b0 || bus.level !== 3'd0) begin
            bad++;
            $display("FAIL rst_async: got v=%0b d=%0d idx=%0d last=%0b lvl=%0d want all 0",
                     bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
            bad++;
            $display("FAIL rst_discard: got v=%0b lvl=%0d want 0 0", bus.out_valid, bus.level);
        end
        bus.in_valid = 1'b1; bus.in_data = mkframe(900, -2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain_frame("rst_next", 900, -2);
    endtask

    task automatic test_saturate();
        bus.out_ready = 1'b0;
        for (int n = 0; n < 259; n++) begin
            bus.in_valid = 1'b1; bus.in_data = mkframe(n, 1);
            @(negedge clk);
        end
        total++;
        if (bus.drop_cnt !== 8'd255 || bus.overflow !== 1'b1 || bus.level !== 3'd4) begin
            bad++;
            $display("FAIL sat_255: got drop=%0d ovf=%0b lvl=%0d want 255 1 4",
                     bus.drop_cnt, bus.overflow, bus.level);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.drop_cnt !== 8'd255) begin
            bad++;
            $display("FAIL sat_hold: got drop=%0d want 255", bus.drop_cnt);
        end
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        total++;
        if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL sat_clear: got ovf=%0b drop=%0d want 0 0", bus.overflow, bus.drop_cnt);
        end
        bus.in_valid = 1'b1; bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.ovf_clr = 1'b0;
        total++;
        if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1 || bus.level !== 3'd4) begin
            bad++;
            $display("FAIL sat_drop_vs_clr: got ovf=%0b drop=%0d lvl=%0d want 1 1 4",
                     bus.overflow, bus.drop_cnt, bus.level);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_pop_write();
        test_random_stall();
        test_midframe_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/topk_stream_serializer.md
TOPK_STREAM_SERIALIZER -- requirements
Module: topk_stream_serializer

Interface
REQ-001 Parameter M, default 3: log2 of elements per input frame; K = 2**M elements of 16-bit signed each.
REQ-002 Parameter DEPTH, default 4: frame buffer capacity in frames; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  one-cycle frame strobe from the partial sorter's output_valid; no backpressure is available upstream.
REQ-006 in_data  input  K*16  signed frame from the sorter's out_data_reg; element i occupies bits [i*16 +: 16].
REQ-007 out_valid  output  1  stream element available.
REQ-008 out_ready  input  1  downstream accepts element.
REQ-009 out_data  output  16  signed element value.
REQ-010 out_idx  output  M  position of out_data within its frame.
REQ-011 out_last  output  1  high with the element whose out_idx = K-1.
REQ-012 level  output  clog2(DEPTH)+1  frames currently buffered, including a partially drained head frame.
REQ-013 overflow  output  1  sticky; a frame was dropped.
REQ-014 drop_cnt  output  8  dropped-frame count, saturating at 255.
REQ-015 ovf_clr  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-016 The block SHALL buffer whole frames in a circular FIFO of DEPTH entries, each K*16 bits wide, with write and read pointers that wrap modulo DEPTH.
REQ-017 Write: on a clock edge with in_valid=1 and (level<DEPTH or a head-frame pop in the same cycle), in_data SHALL be stored at the write pointer, and the write pointer SHALL advance.
REQ-018 Drop: on an edge with in_valid=1, level=DEPTH and no pop in that cycle, the frame SHALL be discarded, overflow SHALL be set, and drop_cnt SHALL increment unless it is already 255.
REQ-019 ovf_clr=1 SHALL clear overflow and drop_cnt to 0 on that edge; a simultaneous drop SHALL take priority, leaving overflow=1 and drop_cnt=1.
REQ-020 out_valid SHALL equal (level != 0); it SHALL NOT depend combinationally on out_ready.
REQ-021 out_data SHALL be element out_idx of the head frame, and out_idx SHALL come from an internal element counter.
REQ-022 A transfer is out_valid & out_ready. On a transfer, the element counter SHALL increment; out_data, out_idx and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 A transfer with out_idx=K-1 (out_last=1) SHALL pop the head frame, reset the element counter to 0 and advance the read pointer.
REQ-024 When write and pop coincide, level SHALL be unchanged. A write alone SHALL add 1 to level; a pop alone SHALL subtract 1.
REQ-025 Latency: a frame written on edge t SHALL appear with out_valid=1 in the cycle after edge t when the FIFO was empty. Its element 0 SHALL appear first and element K-1 last.
REQ-026 When out_valid=0, out_data, out_idx and out_last SHALL be 0.
REQ-027 With out_ready held at 1 and at least one frame buffered, the block SHALL sustain one element per cycle with no bubble across frame boundaries.

Reset
REQ-028 While rst_n=0, the block SHALL hold pointers, element counter, level, overflow and drop_cnt at 0, and out_valid, out_data, out_idx and out_last at 0.
REQ-029 Reset asserted mid-frame SHALL discard all buffered and partially drained frames. After release, the first element SHALL come from the next frame written.

Verification
REQ-030 M=3. Write one frame with elements 70,60,50,40,30,20,10,0 and hold out_ready=1 -> 8 consecutive transfers of 70..0, out_idx 0..7, out_last only on value 0, then level=0.
REQ-031 Hold out_ready=0 and write 5 frames with DEPTH=4 -> level=4, overflow=1, drop_cnt=1. Draining SHALL yield only frames 1-4.
REQ-032 With level=4, in_valid and the final-element transfer in the same cycle -> new frame accepted, level stays 4, overflow stays 0.
REQ-033 Toggle out_ready randomly over 6 frames -> outputs held stable during stalls, order preserved and pointers wrap correctly.
REQ-034 Assert rst_n=0 after 3 elements of a frame -> all outputs 0 asynchronously. The next frame after release drains from out_idx=0.
REQ-035 Force 256 drops, then assert ovf_clr -> drop_cnt saturates at 255, then overflow=0 and drop_cnt=0 on the next edge.
